// File: rtl/ram_pkg.sv
// Shared constants and word/address types for the main-memory model.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package ram_pkg;

   localparam int DATA_W      = 32;
   localparam int PORT_ADDR_W = 32;
   localparam int DEF_ADDR_W  = 10;
   localparam int DEF_LATENCY = 4;

   typedef logic [DATA_W-1:0]     word_t;
   typedef logic [DEF_ADDR_W-1:0] ram_addr_t;

endpackage

// File: rtl/ram_if.sv
// Request/response bundle between the cache and the main-memory model.
// Latency: none (wires only).
// Backpressure: requester holds inputs until response is high; changing them aborts.
interface ram_if;
   import ram_pkg::*;

   word_t                  data;
   logic [PORT_ADDR_W-1:0] addr;
   logic                   wr;
   logic                   response;
   word_t                  out;

   modport master (output data, output addr, output wr, input response, input out);
   modport slave  (input data, input addr, input wr, output response, output out);

endinterface

// File: rtl/ram_array.sv
// Single-port synchronous word memory, write-enable plus enabled registered read.
// Latency: one edge for write commit and for read data.
// Backpressure: none; contents and read register are never reset.
module ram_array #(
   parameter int AW = 10,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic          re,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdat,
   output logic [DW-1:0] rdat
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // One port: a write takes priority, otherwise an enabled read updates rdat.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdat;
      end else if (re) begin
         rdat <= mem[addr];
      end
   end

endmodule

// File: rtl/ram_block.sv
// Main-memory model: any input change is a new request, serviced after a fixed countdown.
// Latency: LATENCY edges from acceptance to the memory operation and done.
// Backpressure: none; response is the only completion signal, changed inputs abort.
module ram_block
   import ram_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int LATENCY = DEF_LATENCY
) (
   input  logic clk,
   input  logic rst_n,
   ram_if.slave bus
);

   localparam logic [7:0] LOAD = 8'(LATENCY - 1);

   word_t                  data_q;
   logic [PORT_ADDR_W-1:0] addr_q;
   logic                   wr_q;
   logic                   busy;
   logic [7:0]             cnt;
   logic                   done;
   logic                   out_vld;
   logic                   change;
   logic                   fire;
   word_t                  rd_dat;

   assign change = (bus.data != data_q) | (bus.addr != addr_q) | (bus.wr != wr_q);

   // Completion edge: countdown exhausted while the request is still being presented.
   assign fire = busy & ~change & (cnt == 8'd0);

   // Combinational so a fresh request never sees the previous completion.
   assign bus.response = done & ~change;

   // Read data lives in the array's read register; it reads as zero until the
   // first read completes after reset, since the array itself has no reset.
   assign bus.out = out_vld ? rd_dat : '0;

   ram_array #(.AW(ADDR_W), .DW(DATA_W)) u_array (
      .clk  (clk),
      .we   (fire & wr_q),
      .re   (fire & ~wr_q),
      .addr (addr_q[ADDR_W-1:0]),
      .wdat (data_q),
      .rdat (rd_dat)
   );

   // Request latch and countdown: any change (re)starts a full countdown.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         busy    <= 1'b0;
         cnt     <= 8'd0;
         done    <= 1'b1;
         out_vld <= 1'b0;
      end else if (change) begin
         data_q <= bus.data;
         addr_q <= bus.addr;
         wr_q   <= bus.wr;
         busy   <= 1'b1;
         done   <= 1'b0;
         cnt    <= LOAD;
      end else if (busy) begin
         if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
         end else begin
            busy <= 1'b0;
            done <= 1'b1;
            if (!wr_q) begin
               out_vld <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ram_block.sv
// Randomized and directed bench for ram_block against a transaction-level memory model.
// Latency: checks completion exactly LATENCY edges after each accepted request.
// Backpressure: requests are held for a random number of edges, shorter holds abort.
module tb_ram_block;
   import ram_pkg::*;

   localparam int AW  = DEF_ADDR_W;
   localparam int LAT = DEF_LATENCY;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   ram_if bus ();

   ram_block #(.ADDR_W(AW), .LATENCY(LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   // Reference: memory image, what is known about it, and the outstanding request.
   word_t       m_mem   [0:(1<<AW)-1];
   bit          m_known [0:(1<<AW)-1];
   word_t       m_out;
   bit          m_out_known;
   logic [31:0] r_data;
   logic [31:0] r_addr;
   logic        r_wr;
   int          m_age;   // edges since the request was accepted; complete at LAT

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      r_data      = '0;
      r_addr      = '0;
      r_wr        = 1'b0;
      m_age       = LAT;
      m_out       = '0;
      m_out_known = 1'b1;
   endfunction

   // Effect of one rising edge on the reference, given the inputs presented.
   function automatic void model_edge();
      int idx;
      if (bus.data != r_data || bus.addr != r_addr || bus.wr != r_wr) begin
         r_data = bus.data;
         r_addr = bus.addr;
         r_wr   = bus.wr;
         m_age  = 0;
      end else if (m_age < LAT) begin
         m_age++;
         if (m_age == LAT) begin
            idx = int'(r_addr % (1 << AW));
            if (r_wr) begin
               m_mem[idx]   = r_data;
               m_known[idx] = 1'b1;
            end else begin
               m_out       = m_mem[idx];
               m_out_known = m_known[idx];
            end
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      model_edge();
      #2;
      check("response", {31'd0, bus.response}, {31'd0, m_age >= LAT});
      if (m_out_known) check("out", bus.out, m_out);
   endtask

   task automatic drive(input logic [31:0] d, input logic [31:0] a, input logic w);
      bit changed;
      @(negedge clk);
      bus.data = d;
      bus.addr = a;
      bus.wr   = w;
      #1;
      changed = (d != r_data) || (a != r_addr) || (w != r_wr);
      check("response_comb", {31'd0, bus.response}, {31'd0, !changed && m_age >= LAT});
   endtask

   task automatic request(input logic [31:0] d, input logic [31:0] a, input logic w, input int hold);
      drive(d, a, w);
      repeat (hold) tick();
   endtask

   initial begin
      logic [31:0] d;
      logic [31:0] a;
      logic        w;
      bus.data = '0;
      bus.addr = '0;
      bus.wr   = 1'b0;
      for (int i = 0; i < (1 << AW); i++) begin
         m_known[i] = 1'b0;
         m_mem[i]   = '0;
      end
      model_reset();

      // Reset state with idle inputs.
      #12;
      check("rst_response", {31'd0, bus.response}, 32'd1);
      check("rst_out", bus.out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) tick();

      // Write then read back the same address.
      request(32'hDEADBEEF, 32'd5, 1'b1, LAT);
      request(32'h0, 32'd5, 1'b0, LAT + 3);

      // Read of 7 redirected to 9 mid-flight.
      request(32'h77, 32'd7, 1'b1, LAT);
      request(32'h99, 32'd9, 1'b1, LAT);
      request(32'h0, 32'd7, 1'b0, 2);
      request(32'h0, 32'd9, 1'b0, LAT + 1);

      // Write data replaced before commit: only the second value lands.
      request(32'h11, 32'd3, 1'b1, 2);
      request(32'h22, 32'd3, 1'b1, LAT);
      request(32'h0, 32'd3, 1'b0, LAT + 1);

      // Asynchronous reset during a write to 12 abandons it.
      request(32'hC0C0, 32'd12, 1'b1, LAT);
      request(32'hBAD0, 32'd12, 1'b1, 2);
      @(negedge clk);
      #2;
      rst_n    = 1'b0;
      bus.data = '0;
      bus.addr = '0;
      bus.wr   = 1'b0;
      model_reset();
      #1;
      check("async_rst_response", {31'd0, bus.response}, 32'd1);
      check("async_rst_out", bus.out, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) tick();
      request(32'h0, 32'd12, 1'b0, LAT + 1);

      // Upper address bits are ignored: 0x400 aliases word 0.
      request(32'h5A5A5A5A, 32'h400, 1'b1, LAT);
      request(32'h0, 32'h0, 1'b0, LAT + 1);
      // Identical inputs again: no new request.
      request(32'h0, 32'h0, 1'b0, 2);

      // Random traffic over a small address window, with aborts and repeats.
      for (int n = 0; n < 200; n++) begin
         if ($urandom_range(0, 7) == 0) begin
            d = r_data;
            a = r_addr;
            w = r_wr;
         end else begin
            d = $urandom;
            a = 32'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_FC00);
            w = 1'($urandom_range(0, 1));
         end
         request(d, a, w, $urandom_range(1, LAT + 2));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/ram_block.md
Name: ram_block

Overview:
- Main-memory model sitting behind the direct-mapped cache; services one word read or write at a time with a fixed multi-cycle latency.
- No explicit request strobe: a new request is any change of the {data, addr, wr} inputs relative to the last accepted request.
- Completion is signalled by the level output response.

Parameters:
- DATA_W, 32, word width of data and out.
- ADDR_W, 10, number of address bits used; depth is 2**ADDR_W words; addr[ADDR_W-1:0] selects the word (word addressing, upper bits ignored).
- LATENCY, 4, clock edges from acceptance to completion; legal range 1..255.

Ports:
- clk  in  1  clock, rising-edge active.
- rst_n  in  1  reset, asynchronous, active-low.
- data  in  32  write data.
- addr  in  32  word address.
- wr  in  1  1 = write, 0 = read.
- response  out  1  1 = last accepted request complete and inputs unchanged since.
- out  out  32  read data of the most recent completed read.

Behaviour:
- Internal state:
  - latched data_q, addr_q, wr_q
  - busy flag
  - countdown counter (8 bits)
  - done flag
  - out register
  - memory array
- Reset (rst_n low, asynchronous):
  - data_q=0, addr_q=0, wr_q=0, busy=0, counter=0, done=1, out=0.
  - Memory contents are not cleared; they are preserved across reset and undefined at power-up.
- change = (data!=data_q) | (addr!=addr_q) | (wr!=wr_q).
- response = done & ~change, combinational. It drops in the same cycle the inputs change, so a requester never sees a stale completion.
- Acceptance, at a rising edge with change=1:
  - latch inputs into data_q/addr_q/wr_q
  - busy=1, done=0, counter=LATENCY-1
- Countdown, at a rising edge with change=0 and busy=1:
  - counter>0: decrement.
  - counter==0, this is the completion edge:
    - if wr_q: mem[addr_q]=data_q
    - else: out=mem[addr_q]
    - busy=0, done=1
- Latency: request accepted at edge E0; memory operation and done at edge E0+LATENCY; response high after that edge.
- Idle (busy=0, change=0): nothing changes; response stays 1 and out holds.
- Writes never modify out. out holds its value until the next completed read.
- Inputs changing mid-operation: the current request is aborted (an uncommitted write is dropped) and the new request is accepted at that edge with a full LATENCY reload.
- Re-presenting identical inputs after completion is not a new request; response stays 1 and no second access occurs.
- Read-after-write to the same address returns the written data, because the write commits before the read is accepted.
- Reset mid-operation: the access is abandoned; no memory write occurs unless its completion edge has already passed.
- Reset clears the latched inputs to 0. With inputs then at 0, response=1 and no access runs; any non-zero input starts a request on the next edge.

Decomposition:
- Shared package ram_pkg:
  - DATA_W and default ADDR_W/LATENCY constants
  - typedefs word_t (DATA_W bits) and ram_addr_t (ADDR_W bits)
- One natural sub-module ram_array:
  - single-port synchronous memory with write enable, address, write data and registered read data, no reset
  - ram_block holds the change detector, countdown FSM (IDLE/BUSY via busy flag) and response logic.

Test Plan:
- Reset, then hold data=0, addr=0, wr=0 -> response=1, out=0, no access started.
- Write data=0xDEADBEEF, addr=5, wr=1 -> response goes 0 the same cycle; 1 exactly LATENCY (4) edges later; out unchanged (0).
- Then read addr=5, wr=0, data=0 -> response 0 for 4 edges, then 1 with out=0xDEADBEEF; out holds while inputs stay static.
- Change addr from 7 to 9 two edges into a read of addr 7 -> no completion for 7; response rises 4 edges after the change with out=mem[9].
- Write 0x11 to addr 3, then change data to 0x22 before completion -> mem[3]=0x22, never 0x11; a later read of addr 3 returns 0x22.
- Assert rst_n low asynchronously during a busy write to addr 12 -> response=1 immediately, out=0; a later read of addr 12 returns its pre-write content; addr bits above ADDR_W ignored (addr 0x400 aliases addr 0).
